// File: rtl/mux_key_arbiter.sv
// Round-robin arbiter in front of a shared keyed lookup table (key -> OR of matching data).
// Exactly one requester is served per accept; the result goes out through a one-entry registered response port.
module mux_key_arbiter #(
    parameter int NR_REQ      = 4,
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 3,
    parameter int DATA_LEN    = 8,
    parameter bit HAS_DEFAULT = 1'b1,
    parameter int ID_LEN      = $clog2(NR_REQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NR_REQ-1:0]                   req_valid,
    output logic [NR_REQ-1:0]                   req_ready,
    input  logic [NR_REQ*KEY_LEN-1:0]           req_key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    input  logic [DATA_LEN-1:0]                 default_out,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [DATA_LEN-1:0]                 rsp_data,
    output logic [ID_LEN-1:0]                   rsp_id,
    output logic                                rsp_hit,
    output logic [15:0]                         miss_cnt
);
    localparam int P = KEY_LEN + DATA_LEN;

    // Handshake: a transfer happens on any rising edge where valid && ready are both high.
    // req_ready depends combinationally on req_valid/rsp_ready; rsp_* come straight from flops.

    logic [ID_LEN-1:0]   ptr;
    logic [ID_LEN-1:0]   win;
    logic                win_any;
    logic                can_accept;
    logic                accept;
    logic [KEY_LEN-1:0]  win_key;
    logic [DATA_LEN-1:0] lk_or;
    logic [DATA_LEN-1:0] lk_data;
    logic                lk_hit;

    assign can_accept = !rsp_valid || rsp_ready;

    // Scan from the farthest position back to ptr so the closest valid requester wins.
    always_comb begin
        int idx;
        win     = '0;
        win_any = 1'b0;
        idx     = 0;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NR_REQ;
            if (req_valid[idx]) begin
                win     = ID_LEN'(idx);
                win_any = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && win_any && can_accept)
            req_ready[win] = 1'b1;
    end

    assign accept  = |(req_valid & req_ready);
    assign win_key = req_key[int'(win)*KEY_LEN +: KEY_LEN];

    // Duplicate keys merge by OR rather than by priority.
    always_comb begin
        lk_or  = '0;
        lk_hit = 1'b0;
        for (int n = 0; n < NR_KEY; n++) begin
            if (lut[P*n + DATA_LEN +: KEY_LEN] == win_key) begin
                lk_hit = 1'b1;
                lk_or  = lk_or | lut[P*n +: DATA_LEN];
            end
        end
    end

    assign lk_data = lk_hit ? lk_or : (HAS_DEFAULT ? default_out : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_hit   <= 1'b0;
            ptr       <= '0;
            miss_cnt  <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lk_data;
            rsp_id    <= win;
            rsp_hit   <= lk_hit;
            ptr       <= (int'(win) == NR_REQ - 1) ? '0 : win + 1'b1;
            if (!lk_hit && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end else if (rsp_ready) begin
            // Drain only clears valid; the data fields keep their last values.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_key_arbiter.sv
// Bench for mux_key_arbiter: a reference arbiter/lookup model predicts grants and pushes responses to a scoreboard.
// Two instances share the stimulus: one returning default_out on a miss, one returning zero.
module tb_mux_key_arbiter;
    localparam int NR_REQ   = 4;
    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 3;
    localparam int DATA_LEN = 8;
    localparam int ID_LEN   = 2;
    localparam int P        = KEY_LEN + DATA_LEN;

    logic                       clk;
    logic                       rst_n;
    logic [NR_REQ-1:0]          req_valid;
    logic [NR_REQ*KEY_LEN-1:0]  req_key;
    logic [NR_KEY*P-1:0]        lut;
    logic [DATA_LEN-1:0]        default_out;
    logic                       rsp_ready;

    logic [NR_REQ-1:0]   req_ready,  req_ready_nd;
    logic                rsp_valid,  rsp_valid_nd;
    logic [DATA_LEN-1:0] rsp_data,   rsp_data_nd;
    logic [ID_LEN-1:0]   rsp_id,     rsp_id_nd;
    logic                rsp_hit,    rsp_hit_nd;
    logic [15:0]         miss_cnt,   miss_cnt_nd;

    logic [KEY_LEN-1:0]  keys  [NR_REQ];
    logic [KEY_LEN-1:0]  lut_k [NR_KEY];
    logic [DATA_LEN-1:0] lut_d [NR_KEY];

    // Scoreboard entry: {data with default, data without default, id, hit}
    logic [2*DATA_LEN+ID_LEN:0] exp_q[$];

    int          n_cmp;
    int          n_err;
    int          m_ptr;
    logic        m_valid;
    logic [15:0] m_miss;

    mux_key_arbiter #(.HAS_DEFAULT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .lut(lut), .default_out(default_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_hit(rsp_hit), .miss_cnt(miss_cnt)
    );

    mux_key_arbiter #(.HAS_DEFAULT(1'b0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_nd),
        .req_key(req_key), .lut(lut), .default_out(default_out),
        .rsp_valid(rsp_valid_nd), .rsp_ready(rsp_ready), .rsp_data(rsp_data_nd),
        .rsp_id(rsp_id_nd), .rsp_hit(rsp_hit_nd), .miss_cnt(miss_cnt_nd)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_key = '0;
        lut     = '0;
        for (int i = 0; i < NR_REQ; i++) req_key[i*KEY_LEN +: KEY_LEN] = keys[i];
        for (int n = 0; n < NR_KEY; n++) lut[n*P +: P] = {lut_k[n], lut_d[n]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2*DATA_LEN+ID_LEN:0] model_lookup(input logic [KEY_LEN-1:0] key, input int id);
        logic [DATA_LEN-1:0] d;
        logic                h;
        d = '0;
        h = 1'b0;
        for (int n = 0; n < NR_KEY; n++)
            if (lut_k[n] == key) begin
                h = 1'b1;
                d = d | lut_d[n];
            end
        if (h) return {d, d, ID_LEN'(id), 1'b1};
        return {default_out, 8'h00, ID_LEN'(id), 1'b0};
    endfunction

    // One clock: check at the falling edge, update the model at the rising edge, then drive at +1.
    task automatic cycle();
        logic [NR_REQ-1:0]          exp_rdy;
        logic [2*DATA_LEN+ID_LEN:0] e;
        int                         win;
        @(negedge clk);
        exp_rdy = '0;
        win     = -1;
        if (rst_n && (!m_valid || rsp_ready))
            for (int k = 0; k < NR_REQ; k++)
                if (win < 0 && req_valid[(m_ptr + k) % NR_REQ]) win = (m_ptr + k) % NR_REQ;
        if (win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("req_ready_nd", 32'(req_ready_nd), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        check("miss_cnt_nd", 32'(miss_cnt_nd), 32'(m_miss));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q[0];
                check("rsp_data", 32'(rsp_data), 32'(e[18:11]));
                check("rsp_data_nd", 32'(rsp_data_nd), 32'(e[10:3]));
                check("rsp_id", 32'(rsp_id), 32'(e[2:1]));
                check("rsp_hit", 32'(rsp_hit), 32'(e[0]));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_miss  = '0;
            exp_q.delete();
        end else begin
            if (m_valid && rsp_ready) m_valid = 1'b0;
            if (win >= 0) begin
                e = model_lookup(keys[win], win);
                exp_q.push_back(e);
                m_valid = 1'b1;
                m_ptr   = (win + 1) % NR_REQ;
                if (!e[0] && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            end
        end
        #1;
    endtask

    // Idle cycle that also checks the held register fields directly.
    task automatic check_regs(input string tag, input logic [7:0] d, input logic [1:0] id, input logic h);
        req_valid = '0;
        @(negedge clk);
        check({tag, "_data"}, 32'(rsp_data), 32'(d));
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_hit"}, 32'(rsp_hit), 32'(h));
        check({tag, "_valid"}, 32'(rsp_valid), 32'(m_valid));
        @(posedge clk);
        if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_keys(input int k0, input int k1, input int k2, input int k3);
        keys[0] = KEY_LEN'(k0);
        keys[1] = KEY_LEN'(k1);
        keys[2] = KEY_LEN'(k2);
        keys[3] = KEY_LEN'(k3);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        m_ptr       = 0;
        m_valid     = 1'b0;
        m_miss      = '0;
        rst_n       = 1'b0;
        req_valid   = '0;
        rsp_ready   = 1'b1;
        default_out = 8'hA5;
        for (int n = 0; n < NR_KEY; n++) begin
            lut_k[n] = KEY_LEN'(n);
            lut_d[n] = 8'h11 << n;
        end
        set_keys(0, 0, 0, 0);

        cycle();
        do_reset();
        check_regs("reset", 8'h00, 2'd0, 1'b0);

        // Single request from requester 2, key 1
        set_keys(0, 0, 1, 0);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        check_regs("drained", 8'h22, 2'd2, 1'b1);

        // Fairness from reset
        do_reset();
        set_keys(0, 1, 2, 3);
        req_valid = 4'b1111;
        repeat (9) cycle();

        // Backpressure: table changes while held must not alter the response
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                lut_d[0]    = 8'h5A;
                lut_d[1]    = 8'hC3;
                default_out = 8'h3C;
            end
            cycle();
        end
        lut_d[0]    = 8'h11;
        lut_d[1]    = 8'h22;
        default_out = 8'hA5;
        rsp_ready   = 1'b1;
        repeat (3) cycle();
        req_valid = '0;
        cycle();

        // Random mix of keys, valids and ready
        for (int c = 0; c < 40; c++) begin
            set_keys($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            req_valid = NR_REQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();

        // Miss on key 7
        do_reset();
        set_keys(7, 0, 0, 0);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        check_regs("miss", 8'hA5, 2'd0, 1'b0);

        // Duplicate key 0 in entries 0 and 3
        lut_k[3] = 3'd0;
        set_keys(0, 0, 0, 0);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        cycle();
        check_regs("dup", 8'h99, 2'd1, 1'b1);
        lut_k[3] = 3'd3;

        // Reset while a response is held and ptr == 2
        do_reset();
        set_keys(0, 1, 2, 3);
        req_valid = 4'b1111;
        repeat (2) cycle();
        rsp_ready = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        check_regs("mid_reset", 8'h00, 2'd0, 1'b0);
        req_valid = 4'b1111;
        repeat (2) cycle();
        req_valid = '0;
        cycle();

        // miss_cnt saturation
        do_reset();
        set_keys(7, 7, 7, 7);
        req_valid = 4'b0001;
        for (int c = 0; c < 70000 && m_miss != 16'hFFFF; c++) cycle();
        check("miss_sat_reached", 32'(m_miss), 32'hFFFF);
        repeat (3) cycle();
        req_valid = '0;
        cycle();
        check("miss_sat_hold", 32'(miss_cnt), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_key_arbiter.md
# mux_key_arbiter

Round-robin arbiter that shares a single keyed lookup table (key → data, OR-of-matches, optional default) among `NR_REQ` requesters. Each cycle it grants at most one requester, performs the lookup on that requester's key against the shared `lut`, and returns the result, requester ID and hit flag through a registered valid/ready response port. It is the sequencing front end for keyed-mux lookups that several clients must share.

## Interface
- `NR_REQ`, 4, number of requesters (≥2)
- `NR_KEY`, 4, number of lut entries
- `KEY_LEN`, 3, key width
- `DATA_LEN`, 8, data width
- `HAS_DEFAULT`, 1, 1: a miss returns `default_out`; 0: a miss returns 0
- `ID_LEN`, `$clog2(NR_REQ)`, width of requester ID

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NR_REQ  per-requester request valid
- `req_ready`  out  NR_REQ  per-requester grant (combinational, one-hot or zero)
- `req_key`  in  NR_REQ*KEY_LEN  requester i's key at `[KEY_LEN*(i+1)-1:KEY_LEN*i]`
- `lut`  in  NR_KEY*(KEY_LEN+DATA_LEN)  entry n at `[P*(n+1)-1:P*n]`, P=KEY_LEN+DATA_LEN; key in the upper KEY_LEN bits, data in the lower DATA_LEN bits
- `default_out`  in  DATA_LEN  miss value when HAS_DEFAULT=1
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data`  out  DATA_LEN  lookup result
- `rsp_id`  out  ID_LEN  index of served requester
- `rsp_hit`  out  1  at least one lut key matched
- `miss_cnt`  out  16  saturating count of accepted lookups with `rsp_hit`=0

## Operation
- Lookup (combinational, on the granted key): data = bitwise OR of the data fields of every entry whose key equals the granted key; hit = OR of the matches. With no hit, the result is `default_out` if HAS_DEFAULT=1, else 0. Duplicate keys are OR-merged, not prioritized.
- Single-entry output register `{rsp_data, rsp_id, rsp_hit}` qualified by `rsp_valid`.
- `can_accept` = `!rsp_valid || rsp_ready`.
- Arbitration: round-robin pointer `ptr` (ID_LEN bits). Search `req_valid` starting at `ptr`, wrapping modulo NR_REQ; the first asserted requester wins. `req_ready[win]` = `can_accept`; all other `req_ready` bits are 0. `req_ready` is all-zero when no request is valid or `rst_n`=0.
- On an accept edge (some `req_valid[i] && req_ready[i]`):
  - load the output register with the lookup of `req_key[i]` against the current `lut`/`default_out`;
  - set `rsp_valid`=1;
  - set `ptr` = (i+1) mod NR_REQ;
  - if no hit, increment `miss_cnt` (held at 0xFFFF once reached).
- On a drain edge with no accept (`rsp_valid && rsp_ready`, no request): `rsp_valid`→0. The data fields keep their values.
- While `rsp_valid && !rsp_ready`: the output register, `ptr` and `miss_cnt` are frozen, and no grant is issued.
- `lut` and `default_out` are sampled only at the accept edge. Later changes do not alter a held response.
- Requesters drop `req_valid` only after a grant. The arbiter does not depend on this.

## Timing
- Reset (`rst_n`=0 at an edge): `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_hit`=0, `ptr`=0, `miss_cnt`=0. This overrides any in-flight transaction, and the held response is lost.
- Latency: a request granted at edge k shows `rsp_valid`=1 with its result after edge k.
- Throughput: one lookup per cycle while `rsp_ready`=1. Drain and accept happen in the same cycle with no bubble.
- There is no combinational path from `rsp_ready` to `rsp_*`. There is a combinational path from `rsp_ready`/`req_valid` to `req_ready`.
- `ptr` advances only on accept, never on idle cycles.

## Test plan
Configuration: defaults; lut keys 0,1,2,3 → data 0x11,0x22,0x44,0x88; `default_out`=0xA5.

- Single request, `rsp_ready`=1: req 2 with key 1 → `req_ready`=0b0100 that cycle; next cycle `rsp_valid`=1, `rsp_data`=0x22, `rsp_id`=2, `rsp_hit`=1. Then `rsp_valid`=0 after one more cycle if idle.
- Fairness: all four requesters valid with keys 0,1,2,3 held, `rsp_ready`=1, from reset → grants to 0,1,2,3,0,… on consecutive cycles; responses 0x11,0x22,0x44,0x88 with ids 0..3 back-to-back.
- Backpressure: one accept, then `rsp_ready`=0 for 5 cycles with all `req_valid` high → `req_ready`=0 and `rsp_*` unchanged for all 5 cycles. Raise `rsp_ready` → the next requester after the last winner is granted in that same cycle.
- Miss: key 7 → `rsp_data`=0xA5, `rsp_hit`=0, `miss_cnt` 0→1. Rerun with HAS_DEFAULT=0 → `rsp_data`=0x00. Force `miss_cnt` to 0xFFFF, then another miss → it stays 0xFFFF.
- Duplicate key: entries 0 and 3 both key 0 → lookup of key 0 gives `rsp_data`=0x99, `rsp_hit`=1.
- Reset mid-operation: with `rsp_valid`=1 held under backpressure and `ptr`=2, drive `rst_n`=0 for one edge → all outputs 0, `req_ready`=0 during reset. After release, with all requests valid, requester 0 is granted first.
